icache_ctrl: RTL and testbench



---
 rtl/icache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_icache_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with 4-word lines,
// filled from a fixed-latency pipelined main memory.
module icache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic [15:0] addr,
    input  logic        inv,
    output logic [15:0] data_out,
    output logic        done,
    output logic        hit,
    output logic        stall,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 16 - INDEX_BITS - 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RESPOND = 3'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:1]           req_addr_q;
    logic [1:0]            issue_cnt_q;
    logic [MEM_LAT-1:0]    pipe_vld_q;
    logic [1:0]            pipe_word_q [MEM_LAT];
    logic [LINES-1:0]      valid_q;
    logic                  err_q;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [15:0]           data_mem [LINES][4];

    logic [INDEX_BITS-1:0] cur_index, req_index;
    logic [TAG_BITS-1:0]   cur_tag, req_tag;
    logic [1:0]            cur_off, req_off;

    logic lookup_hit, start_fill, inv_all, err_set, capture, fill_done;

    assign cur_off   = addr[2:1];
    assign cur_index = addr[INDEX_BITS+2:3];
    assign cur_tag   = addr[15:INDEX_BITS+3];
    assign req_off   = req_addr_q[2:1];
    assign req_index = req_addr_q[INDEX_BITS+2:3];
    assign req_tag   = req_addr_q[15:INDEX_BITS+3];

    assign lookup_hit = valid_q[cur_index] && (tag_mem[cur_index] == cur_tag);

    // The oldest pipeline stage holds the word whose data is on mem_rdata now.
    assign capture   = pipe_vld_q[MEM_LAT-1];
    assign fill_done = capture && (pipe_word_q[MEM_LAT-1] == 2'd3) && (state_q == S_WAIT);

    assign err = err_q;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        data_out   = '0;
        done       = 1'b0;
        hit        = 1'b0;
        stall      = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        start_fill = 1'b0;
        inv_all    = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inv) begin
                    inv_all = 1'b1;
                    stall   = rd;
                end else if (rd) begin
                    if (addr[0]) begin
                        err_set = 1'b1;
                    end else if (lookup_hit) begin
                        done     = 1'b1;
                        hit      = 1'b1;
                        data_out = data_mem[cur_index][cur_off];
                    end else begin
                        stall      = 1'b1;
                        start_fill = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {req_addr_q[15:3], issue_cnt_q, 1'b0};
                if (issue_cnt_q == 2'd3) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (fill_done) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                done     = 1'b1;
                data_out = data_mem[req_index][req_off];
                state_d  = S_IDLE;
            end
            default: begin
                err_set = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            issue_cnt_q <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_word_q[i] <= '0;
            end
            valid_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end

            if (start_fill) begin
                req_addr_q  <= addr[15:1];
                issue_cnt_q <= '0;
            end else if (state_q == S_ISSUE) begin
                issue_cnt_q <= issue_cnt_q + 2'd1;
            end

            pipe_vld_q[0]  <= (state_q == S_ISSUE);
            pipe_word_q[0] <= issue_cnt_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_word_q[i] <= pipe_word_q[i-1];
            end

            // The line being refilled is invalid until its last word lands.
            if (inv_all) begin
                valid_q <= '0;
            end else if (start_fill) begin
                valid_q[cur_index] <= 1'b0;
            end else if (fill_done) begin
                valid_q[req_index] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide
    // whether their contents can be observed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (capture) begin
                data_mem[req_index][pipe_word_q[MEM_LAT-1]] <= mem_rdata;
            end
            if (fill_done) begin
                tag_mem[req_index] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized self-checking bench for icache_ctrl against a line-level cache
// model and a pipelined memory model.
module tb_icache_ctrl;

    localparam int INDEX_BITS = 5;
    localparam int MEM_LAT    = 2;
    localparam int LINES      = 1 << INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic        inv = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_out, mem_addr, mem_rdata;
    logic        done, hit, stall, mem_rd, err;

    always #5 clk = ~clk;

    icache_ctrl #(.INDEX_BITS(INDEX_BITS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .rd(rd), .addr(addr), .inv(inv),
        .data_out(data_out), .done(done), .hit(hit), .stall(stall),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .err(err)
    );

    // Memory: contents fixed up front; a read issued in cycle c shows its
    // data for the whole of cycle c+MEM_LAT, garbage otherwise.
    logic [15:0] mem_array [32768];
    logic        hv [MEM_LAT+1];
    logic [15:0] ha [MEM_LAT+1];

    always @(negedge clk) begin
        for (int i = MEM_LAT; i > 0; i--) begin
            hv[i] = hv[i-1];
            ha[i] = ha[i-1];
        end
        hv[0] = mem_rd;
        ha[0] = mem_addr;
    end

    assign mem_rdata = hv[MEM_LAT] ? mem_array[ha[MEM_LAT][15:1]] : 16'hDEAD;

    // Cache model: which memory block each line currently mirrors.
    bit         m_valid [LINES];
    logic [7:0] m_tag   [LINES];
    bit         exp_err;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic cycle_drive(input bit r, input bit i, input logic [15:0] a, input bit rs);
        @(posedge clk);
        #2;
        rd = r; inv = i; addr = a; rst = rs;
        #2;
    endtask

    task automatic cycle_junk();
        cycle_drive(1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic check_outs(input string t, input bit e_done, input bit e_hit, input bit e_stall,
                              input bit e_mem_rd, input logic [15:0] e_maddr, input logic [15:0] e_data);
        check({t, ".done"},  done,     e_done);
        check({t, ".hit"},   hit,      e_hit);
        check({t, ".stall"}, stall,    e_stall);
        check({t, ".mem_rd"}, mem_rd,  e_mem_rd);
        if (e_mem_rd) check({t, ".mem_addr"}, mem_addr, e_maddr);
        check({t, ".data"},  data_out, e_data);
        check({t, ".err"},   err,      exp_err);
    endtask

    task automatic req(input logic [15:0] a, input bit with_inv);
        logic [4:0] idx;
        logic [7:0] tg;
        idx = a[7:3];
        tg  = a[15:8];
        cycle_drive(1'b1, with_inv, a, 1'b0);
        if (with_inv) begin
            check_outs("inv", 0, 0, 1, 0, 0, 0);
            model_clear();
        end else if (a[0]) begin
            check_outs("misal", 0, 0, 0, 0, 0, 0);
            exp_err = 1'b1;
        end else if (m_valid[idx] && m_tag[idx] == tg) begin
            check_outs("hit", 1, 1, 0, 0, 0, mem_array[a[15:1]]);
        end else begin
            check_outs("miss", 0, 0, 1, 0, 0, 0);
            for (int k = 0; k < 4; k++) begin
                cycle_junk();
                check_outs("issue", 0, 0, 1, 1, {a[15:3], 2'(k), 1'b0}, 0);
            end
            for (int j = 0; j < MEM_LAT; j++) begin
                cycle_junk();
                check_outs("wait", 0, 0, 1, 0, 0, 0);
            end
            cycle_junk();
            check_outs("resp", 1, 0, 0, 0, 0, mem_array[a[15:1]]);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic do_reset();
        cycle_drive(1'b0, 1'b0, 16'h0, 1'b1);
        model_clear();
        exp_err = 1'b0;
        cycle_drive(1'b0, 1'b0, 16'h0, 1'b0);
        check_outs("rst", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_cycle();
        cycle_drive(1'b0, 1'b0, 16'($urandom), 1'b0);
        check_outs("idle", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i <= MEM_LAT; i++) begin
            hv[i] = 1'b0;
            ha[i] = '0;
        end
        for (int i = 0; i < 32768; i++) mem_array[i] = 16'($urandom);
        mem_array[0] = 16'h1111;
        mem_array[1] = 16'h2222;
        mem_array[2] = 16'h3333;
        mem_array[3] = 16'h4444;
        model_clear();
        exp_err = 1'b0;

        repeat (3) @(posedge clk);
        do_reset();

        // Cold miss, hit on the filled line, conflict eviction and re-miss.
        req(16'h0000, 1'b0);
        req(16'h0004, 1'b0);
        req(16'h0100, 1'b0);
        req(16'h0000, 1'b0);
        req(16'h0006, 1'b0);

        // Misaligned request: err sticks until reset.
        req(16'h0003, 1'b0);
        idle_cycle();
        idle_cycle();
        do_reset();

        // Invalidate beats a simultaneous read; the next read refills.
        req(16'h0004, 1'b0);
        req(16'h0004, 1'b1);
        req(16'h0004, 1'b0);
        req(16'h0002, 1'b0);

        // Reset in the third issue cycle of a fill.
        do_reset();
        cycle_drive(1'b1, 1'b0, 16'h0000, 1'b0);
        check_outs("mr.miss", 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle_drive(1'b0, 1'b0, 16'h0000, k == 2);
            check_outs("mr.issue", 0, 0, 1, 1, {13'h0, 2'(k), 1'b0}, 0);
        end
        model_clear();
        exp_err = 1'b0;
        for (int j = 0; j < MEM_LAT + 2; j++) idle_cycle();
        req(16'h0000, 1'b0);
        req(16'h0006, 1'b0);

        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [15:0] a;
            a  = {6'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'($urandom), 1'b0};
            op = $urandom_range(0, 99);
            if (op < 4)       do_reset();
            else if (op < 10) req(a, 1'b1);
            else if (op < 13) req(a | 16'h1, 1'b0);
            else if (op < 18) idle_cycle();
            else              req(a, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
